// File: rtl/kbd_pkg.sv
// Shared keyboard-path definitions: PS/2 scancode constants and the
// sequencer state encoding. Also used by the PS/2 receiver and keymap blocks.
package kbd_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_BKSP  = 8'h66;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BREAK = 2'd1,
    ST_EXT   = 2'd2,
    ST_CLEAR = 2'd3
  } kbdState_t;

endpackage

// File: rtl/kbd_regfile_ctrl_if.sv
// Scancode handshake plus register-file write port of the keyboard sequencer.
//   code_in/code_valid/code_ready : byte stream from the PS/2 receiver
//   writeData/writeEnable/writeAddress : register file write port
// master = scancode source / register file side, slave = kbd_regfile_ctrl.
interface kbd_regfile_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [DATA_W-1:0] code_in;
  logic              code_valid;
  logic              code_ready;
  logic [DATA_W-1:0] writeData;
  logic              writeEnable;
  logic [ADDR_W-1:0] writeAddress;

  modport master (
    output code_in, code_valid,
    input  code_ready, writeData, writeEnable, writeAddress
  );

  modport slave (
    input  code_in, code_valid,
    output code_ready, writeData, writeEnable, writeAddress
  );
endinterface

// File: rtl/kbd_regfile_ctrl.sv
// Keyboard-entry sequencer for the VGA text character register file.
// Filters break (F0) and extended (E0) sequences, appends make codes at the
// cursor, handles Backspace, and sweeps all slots to 00 on Escape.
// Ports:
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   bus      : scancode handshake in, register file write port out (slave)
//   cursor   : next free slot, 0..DEPTH
//   full     : cursor == DEPTH
//   busy     : clear sweep in progress
//   overflow : one-cycle pulse when a printable byte is dropped because full
module kbd_regfile_ctrl
  import kbd_pkg::*;
#(
  parameter int DEPTH  = 6,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  kbd_regfile_ctrl_if.slave  bus,
  output logic [ADDR_W-1:0]  cursor,
  output logic               full,
  output logic               busy,
  output logic               overflow
);

  localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] SLOTS     = ADDR_W'(DEPTH);

  kbdState_t         state;
  logic [ADDR_W-1:0] clrIdx;
  logic              accept;

  assign bus.code_ready = (state != ST_CLEAR);
  assign accept         = bus.code_valid && bus.code_ready;
  assign full           = (cursor == SLOTS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= ST_IDLE;
      cursor           <= '0;
      clrIdx           <= '0;
      busy             <= 1'b0;
      overflow         <= 1'b0;
      bus.writeEnable  <= 1'b0;
      bus.writeAddress <= '0;
      bus.writeData    <= '0;
    end else begin
      bus.writeEnable <= 1'b0;
      overflow        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (bus.code_in == DATA_W'(SC_BREAK)) begin
              state <= ST_BREAK;
            end else if (bus.code_in == DATA_W'(SC_EXT)) begin
              state <= ST_EXT;
            end else if (bus.code_in == DATA_W'(SC_ESC)) begin
              state  <= ST_CLEAR;
              clrIdx <= '0;
              busy   <= 1'b1;
            end else if (bus.code_in == DATA_W'(SC_BKSP)) begin
              if (cursor != '0) begin
                bus.writeEnable  <= 1'b1;
                bus.writeAddress <= cursor - 1'b1;
                bus.writeData    <= '0;
                cursor           <= cursor - 1'b1;
              end
            end else if (cursor < SLOTS) begin
              bus.writeEnable  <= 1'b1;
              bus.writeAddress <= cursor;
              bus.writeData    <= bus.code_in;
              cursor           <= cursor + 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end
        end
        ST_BREAK: begin
          if (accept) state <= ST_IDLE;
        end
        ST_EXT: begin
          // E0 F0 xx is an extended release: route through BREAK to drop xx.
          if (accept) begin
            state <= (bus.code_in == DATA_W'(SC_BREAK)) ? ST_BREAK : ST_IDLE;
          end
        end
        ST_CLEAR: begin
          bus.writeEnable  <= 1'b1;
          bus.writeAddress <= clrIdx;
          bus.writeData    <= '0;
          if (clrIdx == LAST_SLOT) begin
            clrIdx <= '0;
            cursor <= '0;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            clrIdx <= clrIdx + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_regfile_ctrl.sv
// Self-checking bench for kbd_regfile_ctrl: directed scenarios followed by
// random scancode traffic, compared cycle by cycle against a behavioural model.
module tb_kbd_regfile_ctrl;

  localparam int DEPTH = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] cursor;
  logic full, busy, overflow;

  always #5 clk = ~clk;

  kbd_regfile_ctrl_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  kbd_regfile_ctrl #(.DEPTH(DEPTH), .DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cursor(cursor), .full(full), .busy(busy), .overflow(overflow)
  );

  // Register file the write port feeds.
  logic [7:0] regMem [16];
  always @(posedge clk) if (bus.writeEnable) regMem[bus.writeAddress] <= bus.writeData;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int         mCursor, mClearLeft;
  bit         mDropNext, mExtSeen;
  logic [7:0] mMem [DEPTH];
  bit         mWritten [DEPTH];
  bit         pWe;
  int         pAddr;
  logic [7:0] pData;
  bit         eWe, eOvf, accepted;
  int         eAddr;
  logic [7:0] eData;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mCursor = 0; mClearLeft = 0; mDropNext = 0; mExtSeen = 0; pWe = 0;
  endtask

  // Decide what the coming clock edge does, from current inputs.
  task automatic modelStep();
    logic [7:0] b;
    if (pWe) begin mMem[pAddr] = pData; mWritten[pAddr] = 1; end
    eWe = 0; eOvf = 0; accepted = 0; eAddr = 0; eData = 0;
    if (mClearLeft > 0) begin
      eWe = 1; eAddr = DEPTH - mClearLeft; eData = 8'h00;
      mClearLeft--;
      if (mClearLeft == 0) mCursor = 0;
    end else if (bus.code_valid) begin
      accepted = 1;
      b = bus.code_in;
      if (mDropNext) mDropNext = 0;
      else if (mExtSeen) begin
        mExtSeen = 0;
        if (b == 8'hF0) mDropNext = 1;
      end
      else if (b == 8'hF0) mDropNext = 1;
      else if (b == 8'hE0) mExtSeen = 1;
      else if (b == 8'h76) mClearLeft = DEPTH;
      else if (b == 8'h66) begin
        if (mCursor > 0) begin mCursor--; eWe = 1; eAddr = mCursor; eData = 8'h00; end
      end
      else if (mCursor < DEPTH) begin eWe = 1; eAddr = mCursor; eData = b; mCursor++; end
      else eOvf = 1;
    end
    pWe = eWe; pAddr = eAddr; pData = eData;
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk); #1;
    chk("writeEnable", 32'(bus.writeEnable), 32'(eWe));
    if (eWe) begin
      chk("writeAddress", 32'(bus.writeAddress), 32'(eAddr));
      chk("writeData", 32'(bus.writeData), 32'(eData));
    end
    chk("cursor", 32'(cursor), 32'(mCursor));
    chk("full", 32'(full), 32'(mCursor == DEPTH));
    chk("busy", 32'(busy), 32'(mClearLeft > 0));
    chk("code_ready", 32'(bus.code_ready), 32'(mClearLeft == 0));
    chk("overflow", 32'(overflow), 32'(eOvf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sendByte(input logic [7:0] b);
    bus.code_in = b;
    bus.code_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (accepted) break;
    end
    chk("accept_timeout", 32'(accepted), 32'd1);
    bus.code_valid = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    chk({tag, "_we"}, 32'(bus.writeEnable), 32'd0);
    chk({tag, "_addr"}, 32'(bus.writeAddress), 32'd0);
    chk({tag, "_data"}, 32'(bus.writeData), 32'd0);
    chk({tag, "_cursor"}, 32'(cursor), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    int r;
    bus.code_in = 8'h00;
    bus.code_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin mMem[i] = 8'h00; mWritten[i] = 0; end
    modelReset();

    // Power-on reset
    #2;
    checkResetOutputs("por");
    #10 rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(bus.code_ready), 32'd1);

    // Append
    sendByte(8'h1C);
    idle(2);

    // Release / extended filtering
    sendByte(8'hF0); sendByte(8'h1C);
    sendByte(8'hE0); sendByte(8'h74);
    sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h74);
    idle(2);
    chk("filter_cursor", 32'(cursor), 32'd1);

    // Empty the slots, then fill to full and overflow
    sendByte(8'h76);
    idle(DEPTH + 2);
    sendByte(8'h15); sendByte(8'h1D); sendByte(8'h24);
    sendByte(8'h2D); sendByte(8'h2C); sendByte(8'h35);
    idle(1);
    chk("full_after_fill", 32'(full), 32'd1);
    sendByte(8'h3C);
    idle(2);
    chk("cursor_after_ovf", 32'(cursor), 32'd6);

    // Backspace down to 3, then once more, then from empty
    sendByte(8'h66); sendByte(8'h66); sendByte(8'h66);
    idle(1);
    sendByte(8'h66);
    idle(1);
    chk("cursor_bksp", 32'(cursor), 32'd2);
    sendByte(8'h76);
    idle(DEPTH + 1);
    sendByte(8'h66);
    idle(2);

    // Clear at cursor 4 with a byte held during the sweep
    sendByte(8'h1A); sendByte(8'h22); sendByte(8'h21); sendByte(8'h2A);
    sendByte(8'h76);
    sendByte(8'h1C);
    idle(2);
    chk("after_clear_cursor", 32'(cursor), 32'd1);

    // Reset in the middle of a sweep
    sendByte(8'h2B); sendByte(8'h34); sendByte(8'h33);
    sendByte(8'h76);
    idle(2);
    rst = 1'b0;
    #1;
    checkResetOutputs("mid_reset");
    modelReset();
    rst = 1'b1;
    #1;
    chk("ready_after_mid_reset", 32'(bus.code_ready), 32'd1);
    idle(2);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 11);
      case (r)
        0: b = 8'hF0;
        1: b = 8'hE0;
        2: b = ($urandom_range(0, 3) == 0) ? 8'h76 : 8'h66;
        3: b = 8'h66;
        default: b = 8'(8'h01 + $urandom_range(0, 8'h7E));
      endcase
      sendByte(b);
      idle($urandom_range(0, 2));
    end
    idle(DEPTH + 3);

    for (int i = 0; i < DEPTH; i++)
      if (mWritten[i]) chk($sformatf("regMem%0d", i), 32'(regMem[i]), 32'(mMem[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kbd_regfile_ctrl.md
Name: kbd_regfile_ctrl

Overview:
Keyboard-entry sequencer for the 8-bit character register file feeding the VGA text renderer. Accepts decoded PS/2 scancode bytes over a valid/ready handshake and filters break (F0) and extended (E0) sequences. Owns the register file write port: appends make codes at a cursor, handles backspace, and runs a multi-cycle clear sweep on Escape. The register file read port stays with the VGA side.

Parameters:
DEPTH, 6, number of character slots written (addresses 0..DEPTH-1)
DATA_W, 8, scancode / register width
ADDR_W, 4, register file address width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
code_in  in  DATA_W  scancode byte from PS/2 receiver
code_valid  in  1  code_in valid; held until accepted
code_ready  out  1  controller can accept a byte this cycle
writeData  out  DATA_W  register file write data
writeEnable  out  1  register file write strobe, one cycle per write
writeAddress  out  ADDR_W  register file write address
cursor  out  ADDR_W  next free slot, 0..DEPTH
full  out  1  cursor == DEPTH
busy  out  1  clear sweep in progress
overflow  out  1  one-cycle pulse when a printable byte is dropped because full

Behaviour:
- Reset (rst low, async): state IDLE; cursor=0; writeEnable=0, writeAddress=0, writeData=0, overflow=0, busy=0, clear index=0. code_ready is 1 once reset releases.
- Accept: a byte is taken when code_valid && code_ready on a rising clk. code_ready = (state != CLEAR), combinational from state.
- All write-port outputs are registered. A write caused by a byte accepted in cycle N appears with writeEnable=1 in cycle N+1 only. writeEnable is 0 in every other cycle.
- IDLE:
  - F0 -> BREAK.
  - E0 -> EXT.
  - 76 (Esc) -> CLEAR, clear index=0.
  - 66 (Backspace):
    - if cursor>0: write 00 to address cursor-1; cursor -= 1.
    - if cursor==0: no write, no state change.
  - Any other byte:
    - if cursor<DEPTH: write byte to address cursor; cursor += 1.
    - else: no write; overflow=1 for one cycle.
- BREAK: the next accepted byte is discarded (key release); -> IDLE. No write.
- EXT:
  - F0 -> BREAK.
  - Any other byte is discarded (extended keys unsupported); -> IDLE.
- CLEAR:
  - Each cycle writes 00 to address = clear index, then increments the index.
  - After the write to DEPTH-1: cursor=0, -> IDLE.
  - The sweep is exactly DEPTH consecutive writeEnable cycles (addresses 0..DEPTH-1 in order). busy=1 and code_ready=0 for all DEPTH cycles.
- full is combinational from cursor. cursor never exceeds DEPTH and never wraps.
- Esc, Backspace, F0 and E0 are never written as characters.
- A byte presented during CLEAR is not accepted. Upstream holds it, and it is accepted in the first IDLE cycle.
- Reset asserted mid-sweep aborts the sweep immediately. Slots not yet cleared keep their contents. cursor=0.
- Widths: cursor and clear index are ADDR_W bits. Compares are unsigned. No arithmetic exceeds DEPTH.

Decomposition:
- Shared package kbd_pkg:
  - scancode constants SC_BREAK=F0, SC_EXT=E0, SC_ESC=76, SC_BKSP=66.
  - state encoding IDLE/BREAK/EXT/CLEAR (2 bits).
  - The PS/2 receiver and future keymap block use the same package.
- No sub-module. Single FSM plus cursor/index counters and registered write-port outputs.

Test Plan:
- Reset: drive rst low mid-run -> all outputs 0 and cursor=0 immediately. After release, code_ready=1.
- Append: send 1C -> cycle after accept: writeEnable=1, writeAddress=0, writeData=1C. cursor=1.
- Release filtering: send F0,1C, then E0,74, then E0,F0,74 -> no writeEnable; cursor unchanged, state IDLE.
- Overflow: send 15,1D,24,2D,2C,35 -> writes to addresses 0..5, full=1. Send 3C -> no write, overflow pulses once, cursor=6.
- Backspace: at cursor=3 send 66 -> write 00 to address 2, cursor=2. From cursor=0, 66 -> no write.
- Clear: with cursor=4, send 76 followed immediately by 1C:
  - 6 consecutive writes of 00 to addresses 0..5.
  - code_ready=0 and busy=1 for those 6 cycles; cursor=0.
  - 1C is then accepted and written to address 0.
